// File: rtl/seq_divider_if.sv
// seq_divider_if
//   Handshake and data bundle for the sequential divider.
//   master : controller side, drives start and operands, observes results.
//   slave  : divider side, samples start and operands, drives results.
//   Signals:
//     i_start    start request, sampled only while o_busy is low
//     i_var1     dividend
//     i_var2     divisor
//     o_quot     quotient (registered)
//     o_rem      remainder (registered)
//     o_busy     operation in progress
//     o_valid    one-cycle pulse, results final
//     o_div_zero last operation had a zero divisor
interface seq_divider_if #(
   parameter int WIDTH = 6
);
   logic             i_start;
   logic [WIDTH-1:0] i_var1;
   logic [WIDTH-1:0] i_var2;
   logic [WIDTH-1:0] o_quot;
   logic [WIDTH-1:0] o_rem;
   logic             o_busy;
   logic             o_valid;
   logic             o_div_zero;

   modport master (
      output i_start, i_var1, i_var2,
      input  o_quot, o_rem, o_busy, o_valid, o_div_zero
   );

   modport slave (
      input  i_start, i_var1, i_var2,
      output o_quot, o_rem, o_busy, o_valid, o_div_zero
   );
endinterface

// File: rtl/seq_divider.sv
// seq_divider
//   Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   A divide by a non-zero divisor takes WIDTH+1 cycles from the accepting
//   edge to o_valid; a zero divisor reports all-ones quotient, remainder =
//   dividend and o_div_zero one cycle after acceptance.
//   Ports:
//     i_clk    clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      seq_divider_if slave modport (start/operands in, results out)
module seq_divider #(
   parameter int WIDTH = 6
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   seq_divider_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   logic [WIDTH-1:0] dvd;      // dividend, shifted left one bit per iteration
   logic [WIDTH-1:0] dvs;      // divisor
   logic [WIDTH-1:0] rem;      // partial remainder, always < divisor
   logic [WIDTH-1:0] quo;      // quotient under construction
   logic [CW-1:0]    cnt;      // iterations remaining
   logic             dz;       // current operation has a zero divisor

   logic [WIDTH:0]   rem_shift;
   logic             rem_ge;
   logic [WIDTH-1:0] rem_sub;

   // Trial subtraction. The true difference is below the divisor, so the
   // low WIDTH bits of the wrapped subtraction are exact.
   always_comb begin
      rem_shift = {rem, dvd[WIDTH-1]};
      rem_ge    = (rem_shift >= {1'b0, dvs});
      rem_sub   = rem_shift[WIDTH-1:0] - dvs;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= IDLE;
         dvd            <= '0;
         dvs            <= '0;
         rem            <= '0;
         quo            <= '0;
         cnt            <= '0;
         dz             <= 1'b0;
         bus.o_quot     <= '0;
         bus.o_rem      <= '0;
         bus.o_busy     <= 1'b0;
         bus.o_valid    <= 1'b0;
         bus.o_div_zero <= 1'b0;
      end else begin
         bus.o_valid <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.i_start) begin
                  dvd        <= bus.i_var1;
                  dvs        <= bus.i_var2;
                  bus.o_busy <= 1'b1;
                  state      <= CALC;
                  // A zero divisor enters CALC with no iterations left, so
                  // the following edge goes straight to DONE with the
                  // preloaded all-ones quotient and remainder = dividend.
                  if (bus.i_var2 == '0) begin
                     cnt <= '0;
                     dz  <= 1'b1;
                     quo <= '1;
                     rem <= bus.i_var1;
                  end else begin
                     cnt <= CW'(WIDTH);
                     dz  <= 1'b0;
                     quo <= '0;
                     rem <= '0;
                  end
               end else begin
                  state <= IDLE;
               end
            end

            CALC: begin
               if (cnt != '0) begin
                  rem <= rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], rem_ge};
                  dvd <= {dvd[WIDTH-2:0], 1'b0};
                  cnt <= cnt - 1'b1;
               end else begin
                  state          <= DONE;
                  bus.o_busy     <= 1'b0;
                  bus.o_valid    <= 1'b1;
                  bus.o_quot     <= quo;
                  bus.o_rem      <= rem;
                  bus.o_div_zero <= dz;
               end
            end

            default: begin
               state      <= IDLE;
               bus.o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
